r200_if: RTL

- Instruction-fetch stage of the r200 pipeline. It drives the decode stage's instrn, pc_addrout and pcp4, and consumes decode's redirect outputs: pcsel, branchif, pc_brtarg, jump_imm and jump_addimm.
- It issues in-order requests to instruction memory and buffers returned words in a small fetch queue.
- On a taken branch or jump it redirects the PC and discards wrong-path responses.

---
 rtl/r200_pkg.sv | 28 ++
 rtl/r200_if_if.sv | 45 ++++
 rtl/r200_fetchq.sv | 68 ++++++
 rtl/r200_if.sv | 135 +++++++++++++
 4 files changed

// File: rtl/r200_pkg.sv
// Shared definitions for the r200 instruction-fetch stage: reset PC default,
// the NOP used as filler, the decode redirect-select encodings and the
// fetch-queue entry layout.
package r200_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    // Redirect select coming back from decode; 2'b11 behaves like sequential.
    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'b00,
        PCSEL_BR  = 2'b01,
        PCSEL_JMP = 2'b10,
        PCSEL_RSV = 2'b11
    } pcsel_e;

    // One buffered fetch: the instruction word and the PC it was fetched from.
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fq_entry_t;

    // Word-align an address by clearing its two low bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/r200_if_if.sv
// Signal bundle between the fetch stage, instruction memory and decode.
//
// Handshakes: a memory request transfers on a cycle where imem_req and
// imem_ack are both high; a response transfers on any cycle with imem_rvalid
// high (no back-pressure, responses come back in request order); an
// instruction transfers to decode on a cycle where if_valid and id_ready are
// both high. pcsel/branchif and the target buses are only meaningful on that
// transfer cycle.
interface r200_if_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic [31:0] instrn;
    logic [31:0] pc_addrout;
    logic [31:0] pcp4;
    logic        if_valid;
    logic        id_ready;

    logic [1:0]  pcsel;
    logic        branchif;
    logic [31:0] pc_brtarg;
    logic [31:0] jump_imm;
    logic [31:0] jump_addimm;

    // Fetch-stage view.
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rvalid, imem_rdata,
        output instrn, pc_addrout, pcp4, if_valid,
        input  id_ready, pcsel, branchif, pc_brtarg, jump_imm, jump_addimm
    );

    // Memory/decode view.
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rvalid, imem_rdata,
        input  instrn, pc_addrout, pcp4, if_valid,
        output id_ready, pcsel, branchif, pc_brtarg, jump_imm, jump_addimm
    );

endinterface

// File: rtl/r200_fetchq.sv
// Small FIFO holding returned instruction words with their PCs. Flush empties
// it in one cycle and wins over push/pop. DEPTH must be a power of two so the
// pointers wrap naturally.
module r200_fetchq #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int              PW   = $clog2(DEPTH);
    localparam int              CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointer and occupancy next-state; a push into a full queue is only
    // allowed when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != FULL) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/r200_if.sv
// r200 instruction-fetch stage: credit-limited in-order requests to
// instruction memory, a fetch queue feeding decode with no added latency,
// and redirect handling that discards wrong-path responses.
module r200_if
    import r200_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          FQ_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    r200_if_if.master bus
);

    localparam int            CW         = $clog2(FQ_DEPTH + 1);
    localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(FQ_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [31:0]   last_pc_q, last_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] fq_count;
    fq_entry_t     fq_head;
    fq_entry_t     fq_push_entry;
    logic [CW:0]   credits_used;
    logic          issue, accept, resp, keep;
    logic          fq_valid, fire, take;
    logic [31:0]   target;
    logic [31:0]   pc_out;

    // Request issue: a word may be requested only while in-flight plus
    // buffered words leave room in the queue, so responses never overflow it.
    always_comb begin
        credits_used = {1'b0, outstanding_q} + {1'b0, fq_count};
        issue        = !rst && (credits_used < CREDIT_MAX);
        accept       = issue && bus.imem_ack;
        resp         = bus.imem_rvalid;
    end

    // Decode handshake and redirect target selection.
    always_comb begin
        fq_valid = (fq_count != '0);
        fire     = fq_valid && bus.id_ready;
        take     = 1'b0;
        target   = '0;
        case (pcsel_e'(bus.pcsel))
            PCSEL_BR: begin
                take   = fire && bus.branchif;
                target = word_align(bus.pc_brtarg);
            end
            PCSEL_JMP: begin
                take   = fire;
                target = word_align(bus.jump_imm + bus.jump_addimm);
            end
            default: begin
                take   = 1'b0;
                target = '0;
            end
        endcase
    end

    // Credit, drop and PC next-state. On a redirect every request still in
    // flight after this cycle (including one accepted now) is wrong-path and
    // must be dropped; a response arriving in the redirect cycle is itself
    // wrong-path and is never enqueued.
    always_comb begin
        outstanding_d = outstanding_q + CW'(accept) - CW'(resp);
        keep          = resp && (drop_cnt_q == '0) && !take;
        fq_push_entry = '{data: bus.imem_rdata, pc: resp_pc_q};
        drop_cnt_d    = drop_cnt_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        if (take) begin
            drop_cnt_d = outstanding_d;
            fetch_pc_d = target;
            resp_pc_d  = target;
        end else begin
            if (resp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
            if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
            if (keep)   resp_pc_d  = resp_pc_q + 32'd4;
        end
        // Remember the last presented PC so pc_addrout holds when empty.
        last_pc_d = fq_valid ? fq_head.pc : last_pc_q;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            last_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            last_pc_q     <= last_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    r200_fetchq #(
        .WIDTH (64),
        .DEPTH (FQ_DEPTH)
    ) u_fetchq (
        .clk     (clk),
        .rst     (rst),
        .push_i  (keep),
        .pop_i   (fire && !take),
        .flush_i (take),
        .data_i  (fq_push_entry),
        .head_o  (fq_head),
        .count_o (fq_count)
    );

    assign pc_out         = fq_valid ? fq_head.pc : last_pc_q;
    assign bus.imem_req   = issue;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.if_valid   = fq_valid;
    assign bus.instrn     = fq_valid ? fq_head.data : NOP_INSTR;
    assign bus.pc_addrout = pc_out;
    assign bus.pcp4       = pc_out + 32'd4;

    // Memory must never return a word that was not requested.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        resp |-> (outstanding_q != '0));

    // The credit rule guarantees a kept response always finds room.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        keep |-> ({1'b0, fq_count} < CREDIT_MAX));

endmodule
